// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings.
// Kept outside the timer so other sequencing blocks can decode its state.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count detection, optional auto-reload
// and a registered one-cycle DONE pulse on each expiry.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | after reset; count held, ENABLE ignored, waiting for LOAD
// ST_RUN     | counting down on ENABLE; terminal decrement at COUNTER == 1
// ST_EXPIRED | count parked at 0, ENABLE ignored until the next LOAD
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ENABLE,
    input  logic            LOAD,
    input  logic [SIZE-1:0] LOAD_VALUE,
    input  logic            AUTO_RELOAD,
    output logic [SIZE-1:0] COUNTER,
    output logic            EMPTY,
    output logic            DONE
);

    localparam logic [SIZE-1:0] CNT_ZERO = '0;
    localparam logic [SIZE-1:0] CNT_ONE  = {{(SIZE-1){1'b0}}, 1'b1};

    timer_state_e    state_q,  state_d;
    logic [SIZE-1:0] count_q,  count_d;
    logic [SIZE-1:0] reload_q, reload_d;
    logic            done_q,   done_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (LOAD) begin
            // LOAD beats everything, including a coincident terminal decrement.
            count_d  = LOAD_VALUE;
            reload_d = LOAD_VALUE;
            state_d  = (LOAD_VALUE != CNT_ZERO) ? ST_RUN : ST_EXPIRED;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (ENABLE) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else if (count_q == CNT_ONE) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CNT_ZERO;
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            // Zero count in RUN is unreachable; park safely without wrapping.
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_EXPIRED: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign COUNTER = count_q;
    assign EMPTY   = (count_q == CNT_ZERO);
    assign DONE    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (SIZE=4) with hand-computed
// expectations, plus hand-written sequences for long count and async reset.
module tb_countdown_timer;

    localparam int SIZE = 4;

    logic            CLK;
    logic            RESET_N;
    logic            ENABLE;
    logic            LOAD;
    logic [SIZE-1:0] LOAD_VALUE;
    logic            AUTO_RELOAD;
    logic [SIZE-1:0] COUNTER;
    logic            EMPTY;
    logic            DONE;

    int checks;
    int errors;

    typedef struct {
        logic            ld;
        logic [SIZE-1:0] lv;
        logic            en;
        logic            ar;
        logic [SIZE-1:0] exp_cnt;
        logic            exp_empty;
        logic            exp_done;
    } vec_t;

    vec_t vecs[$];

    countdown_timer #(.SIZE(SIZE)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .LOAD        (LOAD),
        .LOAD_VALUE  (LOAD_VALUE),
        .AUTO_RELOAD (AUTO_RELOAD),
        .COUNTER     (COUNTER),
        .EMPTY       (EMPTY),
        .DONE        (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int idx, input logic [SIZE-1:0] act,
                       input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [SIZE-1:0] c,
                           input logic e, input logic d);
        chk({tag, "_counter"}, idx, COUNTER, c);
        chk({tag, "_empty"}, idx, {{(SIZE-1){1'b0}}, EMPTY}, {{(SIZE-1){1'b0}}, e});
        chk({tag, "_done"}, idx, {{(SIZE-1){1'b0}}, DONE}, {{(SIZE-1){1'b0}}, d});
    endtask

    // Drive inputs at the falling edge, sample just after the next rising edge.
    task automatic step(input logic ld, input logic [SIZE-1:0] lv, input logic en,
                        input logic ar);
        @(negedge CLK);
        LOAD        = ld;
        LOAD_VALUE  = lv;
        ENABLE      = en;
        AUTO_RELOAD = ar;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic ld, input logic [SIZE-1:0] lv, input logic en,
                       input logic ar, input logic [SIZE-1:0] c, input logic e,
                       input logic d);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
        v.exp_cnt = c; v.exp_empty = e; v.exp_done = d;
        vecs.push_back(v);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RESET_N     = 1'b0;
        ENABLE      = 1'b0;
        LOAD        = 1'b0;
        LOAD_VALUE  = '0;
        AUTO_RELOAD = 1'b0;

        //   ld  lv  en ar   cnt empty done
        add(0,  0, 1, 0,    0, 1, 0);   // IDLE ignores ENABLE
        add(1,  3, 0, 0,    3, 0, 0);   // load 3 -> RUN
        add(0,  0, 1, 0,    2, 0, 0);
        add(0,  0, 1, 0,    1, 0, 0);
        add(0,  0, 1, 0,    0, 1, 1);   // expiry: DONE with first zero
        add(0,  0, 1, 0,    0, 1, 0);   // EXPIRED: no wrap
        add(0,  0, 1, 0,    0, 1, 0);
        add(1,  5, 0, 0,    5, 0, 0);   // load 5, enable 1,0,0,1
        add(0,  0, 1, 0,    4, 0, 0);
        add(0,  0, 0, 0,    4, 0, 0);
        add(0,  0, 0, 0,    4, 0, 0);
        add(0,  0, 1, 0,    3, 0, 0);
        add(0,  0, 1, 1,    2, 0, 0);   // AUTO_RELOAD only matters at terminal
        add(0,  0, 1, 0,    1, 0, 0);
        add(0,  0, 1, 0,    0, 1, 1);
        add(1,  2, 0, 1,    2, 0, 0);   // auto-reload with value 2
        add(0,  0, 1, 1,    1, 0, 0);
        add(0,  0, 1, 1,    2, 0, 1);
        add(0,  0, 1, 1,    1, 0, 0);
        add(0,  0, 1, 1,    2, 0, 1);
        add(0,  0, 1, 1,    1, 0, 0);
        add(1,  9, 1, 1,    9, 0, 0);   // LOAD beats terminal decrement
        add(0,  0, 1, 1,    8, 0, 0);   // still RUN
        add(1,  0, 1, 0,    0, 1, 0);   // load 0 -> EXPIRED, no DONE
        add(0,  0, 1, 0,    0, 1, 0);
        add(0,  0, 1, 0,    0, 1, 0);
        add(0,  0, 1, 0,    0, 1, 0);
        add(0,  0, 1, 0,    0, 1, 0);
        add(1,  1, 0, 1,    1, 0, 0);   // reload value 1: DONE every enabled cycle
        add(0,  0, 1, 1,    1, 0, 1);
        add(0,  0, 1, 1,    1, 0, 1);
        add(0,  0, 1, 0,    0, 1, 1);
        add(0,  0, 1, 0,    0, 1, 0);

        // Reset state while RESET_N is low, before any clock edge matters.
        #2;
        chk_all("reset", 0, 0, 1, 0);

        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
            chk_all("vec", i, vecs[i].exp_cnt, vecs[i].exp_empty, vecs[i].exp_done);
        end

        // Maximum load: 15 enabled cycles to expiry.
        step(1, 15, 0, 0);
        chk_all("max_load", 0, 15, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 1, 0);
            chk_all("max_run", i, 4'(15 - i), (i == 15), (i == 15));
        end

        // Asynchronous reset between edges while counting.
        step(1, 6, 0, 0);
        chk_all("pre_rst", 0, 6, 0, 0);
        step(0, 0, 0, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 1, 0);
        @(posedge CLK);
        #1;
        chk_all("held_rst", 0, 0, 1, 0);
        #2;
        RESET_N = 1'b1;
        step(0, 0, 1, 0);
        chk_all("post_rst_idle", 0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_all("post_rst_idle", 1, 0, 1, 0);
        step(1, 4, 1, 0);
        chk_all("post_rst_load", 0, 4, 0, 0);
        step(0, 0, 1, 0);
        chk_all("post_rst_run", 0, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
